// File: rtl/mem_unit_if.sv
// Memory-stage bus for mem_unit.
// The master side is the environment around the unit: the control unit
// issues requests, and the RAM returns read data and ready.
// The slave side is the mem_unit itself.
interface mem_unit_if;
   // control unit -> mem_unit
   logic        en;
   logic        is_store;
   logic [15:0] addr;
   logic [15:0] wdata;
   // mem_unit -> control unit / register file
   logic        busy;
   logic        done;
   logic        err;
   logic [15:0] rdata;
   logic        wb_we;
   // mem_unit -> RAM
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_re;
   logic        ram_we;
   // RAM -> mem_unit
   logic [15:0] ram_rdata;
   logic        ram_ready;

   modport master (
      output en, is_store, addr, wdata, ram_rdata, ram_ready,
      input  busy, done, err, rdata, wb_we, ram_addr, ram_wdata, ram_re, ram_we
   );

   modport slave (
      input  en, is_store, addr, wdata, ram_rdata, ram_ready,
      output busy, done, err, rdata, wb_we, ram_addr, ram_wdata, ram_re, ram_we
   );
endinterface

// File: rtl/mem_unit.sv
// Memory-stage sequencer: accepts one load/store request at a time from the
// control unit, holds the RAM strobe until the RAM reports ready, and aborts
// the access after TIMEOUT cycles without ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for en; the only state that accepts a request
// ACCESS | strobe held on the RAM, counting wait cycles
// DONE   | one-cycle completion pulse (wb_we for a load)
// ERR    | one-cycle completion pulse with err, rdata untouched
//
// Every output is a flop that is set on the edge entering a state, so the
// outputs are glitch-free and nothing on the request side reaches a RAM
// strobe combinationally.
module mem_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   mem_unit_if.slave  bus
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_ERR    = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        is_store_q;
   logic [15:0] ram_addr_q;
   logic [15:0] ram_wdata_q;
   logic [15:0] rdata_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;
   logic        wb_we_q;
   logic        ram_re_q;
   logic        ram_we_q;

   assign cnt_d = cnt_q + 8'd1;

   // Request sequencing, wait counting and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         is_store_q  <= 1'b0;
         ram_addr_q  <= 16'h0000;
         ram_wdata_q <= 16'h0000;
         rdata_q     <= 16'h0000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wb_we_q     <= 1'b0;
         ram_re_q    <= 1'b0;
         ram_we_q    <= 1'b0;
      end else begin
         // completion flags are single-cycle pulses
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wb_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.en) begin
                  is_store_q  <= bus.is_store;
                  ram_addr_q  <= bus.addr;
                  ram_wdata_q <= bus.wdata;
                  cnt_q       <= 8'd0;
                  busy_q      <= 1'b1;
                  ram_re_q    <= ~bus.is_store;
                  ram_we_q    <= bus.is_store;
                  state_q     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               // ready wins over the timeout when both land on the same edge
               if (bus.ram_ready) begin
                  ram_re_q <= 1'b0;
                  ram_we_q <= 1'b0;
                  done_q   <= 1'b1;
                  wb_we_q  <= ~is_store_q;
                  if (!is_store_q) begin
                     rdata_q <= bus.ram_rdata;
                  end
                  state_q  <= S_DONE;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_q == CNT_LAST) begin
                     ram_re_q <= 1'b0;
                     ram_we_q <= 1'b0;
                     done_q   <= 1'b1;
                     err_q    <= 1'b1;
                     state_q  <= S_ERR;
                  end
               end
            end
            S_DONE, S_ERR: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q   <= 1'b0;
               ram_re_q <= 1'b0;
               ram_we_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.wb_we     = wb_we_q;
   assign bus.rdata     = rdata_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.ram_re    = ram_re_q;
   assign bus.ram_we    = ram_we_q;

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed scenarios plus randomized load/store traffic,
// checked against a transaction-level expectation (access length, outcome,
// last successful load value).
module tb_mem_unit;

   localparam int TIMEOUT = 16;

   logic clk;
   logic reset;
   mem_unit_if bus ();

   int n_cmp;
   int n_mis;
   logic [15:0] exp_rdata;

   mem_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One request from an idle unit. The RAM answers after 'waits' stall
   // cycles (never, if waits >= TIMEOUT). With poke set, en is held high
   // with a conflicting request for the whole access and the completion cycle.
   task automatic run_txn(input logic st, input logic [15:0] a, input logic [15:0] wd,
                          input int waits, input logic [15:0] rd, input bit poke);
      bit timed_out;
      int n_acc;
      timed_out = (waits >= TIMEOUT);
      n_acc     = timed_out ? TIMEOUT : waits + 1;

      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_re",   32'(bus.ram_re), 0);
      chk("idle_we",   32'(bus.ram_we), 0);
      bus.en       = 1'b1;
      bus.is_store = st;
      bus.addr     = a;
      bus.wdata    = wd;

      for (int k = 0; k < n_acc; k++) begin
         @(negedge clk);
         if (poke) begin
            bus.en       = 1'b1;
            bus.is_store = ~st;
            bus.addr     = 16'h0FFF;
            bus.wdata    = ~wd;
         end else begin
            bus.en       = 1'b0;
            bus.is_store = 1'($urandom);
            bus.addr     = 16'($urandom);
            bus.wdata    = 16'($urandom);
         end
         chk("acc_busy",  32'(bus.busy), 1);
         chk("acc_re",    32'(bus.ram_re), 32'(!st));
         chk("acc_we",    32'(bus.ram_we), 32'(st));
         chk("acc_addr",  32'(bus.ram_addr), 32'(a));
         chk("acc_wdata", 32'(bus.ram_wdata), 32'(wd));
         chk("acc_done",  32'(bus.done), 0);
         bus.ram_ready = (k == waits);
         bus.ram_rdata = (k == waits) ? rd : 16'($urandom);
      end

      @(negedge clk);
      bus.ram_ready = 1'b0;
      bus.ram_rdata = 16'($urandom);
      if (!timed_out && !st) exp_rdata = rd;
      chk("cpl_done",  32'(bus.done), 1);
      chk("cpl_err",   32'(bus.err), 32'(timed_out));
      chk("cpl_wb_we", 32'(bus.wb_we), 32'(!timed_out && !st));
      chk("cpl_rdata", 32'(bus.rdata), 32'(exp_rdata));
      chk("cpl_busy",  32'(bus.busy), 1);
      chk("cpl_re",    32'(bus.ram_re), 0);
      chk("cpl_we",    32'(bus.ram_we), 0);

      @(negedge clk);
      bus.en = 1'b0;
      chk("post_busy",  32'(bus.busy), 0);
      chk("post_done",  32'(bus.done), 0);
      chk("post_err",   32'(bus.err), 0);
      chk("post_wb_we", 32'(bus.wb_we), 0);
      chk("post_re",    32'(bus.ram_re), 0);
      chk("post_we",    32'(bus.ram_we), 0);
      chk("post_rdata", 32'(bus.rdata), 32'(exp_rdata));
   endtask

   initial begin
      n_cmp         = 0;
      n_mis         = 0;
      exp_rdata     = 16'h0000;
      reset         = 1'b1;
      bus.en        = 1'b1;
      bus.is_store  = 1'b1;
      bus.addr      = 16'hA5A5;
      bus.wdata     = 16'h5A5A;
      bus.ram_rdata = 16'hFFFF;
      bus.ram_ready = 1'b1;

      // reset held two cycles with en asserted
      repeat (2) @(negedge clk);
      chk("rst_busy",  32'(bus.busy), 0);
      chk("rst_done",  32'(bus.done), 0);
      chk("rst_err",   32'(bus.err), 0);
      chk("rst_wb_we", 32'(bus.wb_we), 0);
      chk("rst_re",    32'(bus.ram_re), 0);
      chk("rst_we",    32'(bus.ram_we), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_addr",  32'(bus.ram_addr), 0);
      chk("rst_wdata", 32'(bus.ram_wdata), 0);
      bus.en        = 1'b0;
      bus.ram_ready = 1'b0;
      reset         = 1'b0;

      // directed scenarios
      run_txn(1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF, 1'b0);           // load, zero wait
      run_txn(1'b1, 16'h0004, 16'h1234, 3, 16'h0000, 1'b0);           // store, 3 waits
      run_txn(1'b0, 16'h0030, 16'h0000, 1000, 16'h0000, 1'b0);        // timeout
      run_txn(1'b0, 16'h0020, 16'h0000, 2, 16'hC0DE, 1'b1);           // busy collision
      run_txn(1'b0, 16'h0040, 16'h0000, TIMEOUT - 1, 16'h7777, 1'b0); // ready on last cycle
      run_txn(1'b1, 16'h0044, 16'h9999, TIMEOUT, 16'h0000, 1'b0);     // store timeout

      // reset on the second ACCESS cycle
      @(negedge clk);
      bus.en       = 1'b1;
      bus.is_store = 1'b0;
      bus.addr     = 16'h0050;
      bus.wdata    = 16'h0000;
      @(negedge clk);
      bus.en = 1'b0;
      chk("mrst_re1", 32'(bus.ram_re), 1);
      @(negedge clk);
      chk("mrst_re2", 32'(bus.ram_re), 1);
      reset = 1'b1;
      @(negedge clk);
      reset     = 1'b0;
      exp_rdata = 16'h0000;
      chk("mrst_re",    32'(bus.ram_re), 0);
      chk("mrst_we",    32'(bus.ram_we), 0);
      chk("mrst_busy",  32'(bus.busy), 0);
      chk("mrst_done",  32'(bus.done), 0);
      chk("mrst_rdata", 32'(bus.rdata), 0);
      chk("mrst_addr",  32'(bus.ram_addr), 0);
      @(negedge clk);
      chk("mrst_nodone", 32'(bus.done), 0);
      chk("mrst_idle",   32'(bus.busy), 0);
      run_txn(1'b0, 16'h0060, 16'h0000, 1, 16'h4321, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         run_txn(1'($urandom), 16'($urandom), 16'($urandom),
                 int'($urandom_range(0, TIMEOUT + 3)), 16'($urandom),
                 bit'($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
